seed_index_aligner: RTL and testbench
=====================================

# seed_index_aligner

Parametrised seed-and-extend aligner. On `start` it indexes a packed 2-bit-per-base reference into four per-base seed buckets (A/G/C/T), one position per cycle. It then scans the buckets one entry per cycle for seeds taken from a short read, and reports the alignment index and the reference window at that index. This is the multi-cycle, bounded-depth, handshaked generalisation of the single-shot base-pair memory lookup in the alignment datapath.

## Interface
- `REF_BASES`, 50, reference length in bases.
- `READ_BASES`, 8, short-read length in bases.
- `SEED_BASES`, 4, seed length in bases (≤ READ_BASES).
- `WINDOW_BASES`, 10, output window length in bases (≤ REF_BASES).
- `DEPTH`, 16, entries per bucket.
- `POS_W`, $clog2(REF_BASES), position width.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `start` in 1: begin a job; sampled only in IDLE.
- `reference` in 2*REF_BASES: base i = bits [2i+1:2i].
- `shortread` in 2*READ_BASES: same packing.
- `busy` out 1: job in progress.
- `done` out 1: one-cycle completion pulse.
- `hit` out 1: alignment found.
- `index` out POS_W: reference base index of alignment.
- `sequence` out 2*WINDOW_BASES: reference bases index..index+WINDOW_BASES-1.
- `overflow` out 1: at least one seed dropped because its bucket was full during the last job.

## Operation
- Base code: 00=A, 01=G, 10=C, 11=T. Bucket select = first base of the seed.
- States: IDLE, BUILD, SEARCH, DONE.
- IDLE: on `start`, latch `reference` and `shortread`, clear the four bucket counts and `overflow`, set p=0, and go to BUILD. `start` is ignored in any other state.
- BUILD: one cycle per p = 0..REF_BASES-SEED_BASES. The seed is ref bases p..p+SEED_BASES-1.
  - If the bucket count < DEPTH: write {seed, p} at the count and increment the count.
  - Else: drop the seed and set `overflow` (sticky until the next start).
  - After the last p, go to SEARCH with q=0, e=0.
- SEARCH: q = read offset 0..READ_BASES-SEED_BASES. The query seed is read bases q..q+SEED_BASES-1, taken from the bucket of its first base. Entries are examined one per cycle in insertion order. A bucket with count 0 costs one cycle for that q.
  - An entry is a candidate when all of the following hold: stored seed == query seed, pos ≥ q, and pos−q ≤ REF_BASES−WINDOW_BASES. Subtraction is done in POS_W+1 bits; no wrap is allowed.
  - On the first accepted candidate, go to DONE with hit=1, index=pos−q, sequence=ref window.
  - Search order is: smallest q first, then earliest entry.
  - When all q are exhausted with no candidate, go to DONE with hit=0, index=0, sequence=0.
- DONE: `done`=1 for one cycle, then return to IDLE. `hit`, `index`, `sequence` and `overflow` hold until the next `start` is accepted. On that start they clear to 0.
- Reset (any time, including mid-job): state IDLE, all outputs 0, bucket counts 0. No `done` is issued for the aborted job. Bucket storage is not reset.

## Timing
- `start` is sampled at edge 0. `busy`=1 from edge 0 through the DONE cycle inclusive.
- BUILD takes REF_BASES−SEED_BASES+1 cycles (47 at defaults).
- SEARCH takes the sum over the examined q of max(1, entries examined), and stops at the accepting entry.
- DONE takes 1 cycle. Results are registered and valid in the same cycle as `done`.
- Worst-case job at defaults: 47 + 5·16 + 1 = 128 cycles.

## Configuration
- `SEED_VERIFY_EN` defined: a candidate is additionally required to satisfy index+READ_BASES ≤ REF_BASES and ref bases index..index+READ_BASES−1 == the full read. The full-read compare is combinational, in the same cycle as the seed compare. On mismatch, scanning continues with the next entry.
- `SEED_VERIFY_EN` not defined: the first seed-level candidate is accepted.

## Test plan
- Reset check: drive `reset`=0 mid-job, then release → busy=0, done=0, hit=0, index=0, sequence=0, overflow=0. No done follows until a new `start`.
- Exact hit: reference with unique 4-mers, shortread = ref bases 20..27 → done after 47+k cycles, hit=1, index=20, sequence=reference[59:40], overflow=0.
- No match: read of seeds absent from the reference → hit=0, index=0, sequence=0, done exactly once after all 5 q are scanned.
- Boundary: read embedded only at base 45 (>40) → every candidate rejected, hit=0. Same read at base 40 → hit=1, index=40.
- Overflow: reference=0, shortread=0 → bucket A holds 16 entries, overflow=1, hit=1, index=0, sequence=0. A `start` pulsed while busy is ignored (exactly one done).
- Verify mode: decoy matching the first read seed at base 5 and full read at base 30 → index=30 with SEED_VERIFY_EN; index=5 without it.

Source files
------------

// File: rtl/seed_index_aligner.sv
// Seed-and-extend aligner: buckets every reference seed by its first base, then scans the buckets
// for seeds of a short read. Define SEED_VERIFY_EN to also require a full-read match.
module seed_index_aligner #(
  parameter int unsigned REF_BASES    = 50,
  parameter int unsigned READ_BASES   = 8,
  parameter int unsigned SEED_BASES   = 4,
  parameter int unsigned WINDOW_BASES = 10,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned POS_W        = $clog2(REF_BASES)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [2*REF_BASES-1:0]    reference,
  input  logic [2*READ_BASES-1:0]   shortread,
  output logic                      busy,
  output logic                      done,
  output logic                      hit,
  output logic [POS_W-1:0]          index,
  output logic [2*WINDOW_BASES-1:0] seq_window,
  output logic                      overflow
);

  localparam int unsigned SeedW = 2 * SEED_BASES;
  localparam int unsigned WinW  = 2 * WINDOW_BASES;
  localparam int unsigned ReadW = 2 * READ_BASES;
  localparam int unsigned CntW  = $clog2(DEPTH + 1);
  localparam int unsigned EntW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [POS_W-1:0] pos_t;
  typedef logic [POS_W:0]   diff_t;
  typedef logic [CntW-1:0]  cnt_t;

  localparam pos_t  LastP    = pos_t'(REF_BASES - SEED_BASES);
  localparam pos_t  LastQ    = pos_t'(READ_BASES - SEED_BASES);
  localparam diff_t MaxIdx   = diff_t'(REF_BASES - WINDOW_BASES);
  localparam cnt_t  DepthC   = cnt_t'(DEPTH);

  typedef enum logic [1:0] {StIdle, StBuild, StSearch, StDone} state_e;

  state_e              state_q, state_d;
  logic [2*REF_BASES-1:0] ref_q, ref_d;
  logic [ReadW-1:0]    read_q, read_d;
  pos_t                p_q, p_d, q_q, q_d;
  logic [EntW-1:0]     e_q, e_d;
  cnt_t                cnt_q [4];
  cnt_t                cnt_d [4];
  logic                hit_q, hit_d, ovf_q, ovf_d;
  pos_t                idx_q, idx_d;
  logic [WinW-1:0]     seq_q, seq_d;

  // Bucket storage is intentionally left unreset; only entries below the count are ever read.
  logic [SeedW-1:0]    seed_mem [4][DEPTH];
  pos_t                pos_mem  [4][DEPTH];

  logic [SeedW-1:0]    build_seed, query_seed, ent_seed;
  logic [1:0]          build_bkt, query_bkt;
  cnt_t                build_cnt, query_cnt;
  pos_t                ent_pos;
  diff_t               diff;
  logic [WinW-1:0]     win;
  logic                cand, last_entry, wr_en;

  assign build_seed = SeedW'(ref_q >> {p_q, 1'b0});
  assign build_bkt  = build_seed[1:0];
  assign build_cnt  = cnt_q[build_bkt];
  assign query_seed = SeedW'(read_q >> {q_q, 1'b0});
  assign query_bkt  = query_seed[1:0];
  assign query_cnt  = cnt_q[query_bkt];
  assign ent_seed   = seed_mem[query_bkt][e_q];
  assign ent_pos    = pos_mem[query_bkt][e_q];
  assign diff       = {1'b0, ent_pos} - {1'b0, q_q};
  assign win        = WinW'(ref_q >> {diff[POS_W-1:0], 1'b0});
  assign last_entry = (cnt_t'(e_q) + 1'b1) == query_cnt;

`ifdef SEED_VERIFY_EN
  localparam diff_t MaxReadIdx = diff_t'(REF_BASES - READ_BASES);
  logic read_ok;
  assign read_ok = (diff <= MaxReadIdx) &&
                   (ReadW'(ref_q >> {diff[POS_W-1:0], 1'b0}) == read_q);
`else
  logic read_ok;
  assign read_ok = 1'b1;
`endif

  // ent_pos >= q_q is checked explicitly so the POS_W+1 bit difference never wraps.
  assign cand = (ent_seed == query_seed) && (ent_pos >= q_q) && (diff <= MaxIdx) && read_ok;

  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    read_d  = read_q;
    p_d     = p_q;
    q_d     = q_q;
    e_d     = e_q;
    cnt_d   = cnt_q;
    hit_d   = hit_q;
    idx_d   = idx_q;
    seq_d   = seq_q;
    ovf_d   = ovf_q;
    wr_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          ref_d   = reference;
          read_d  = shortread;
          cnt_d   = '{default: '0};
          hit_d   = 1'b0;
          idx_d   = '0;
          seq_d   = '0;
          ovf_d   = 1'b0;
          p_d     = '0;
          state_d = StBuild;
        end
      end
      StBuild: begin
        if (build_cnt < DepthC) begin
          wr_en            = 1'b1;
          cnt_d[build_bkt] = build_cnt + 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
        if (p_q == LastP) begin
          q_d     = '0;
          e_d     = '0;
          state_d = StSearch;
        end else begin
          p_d = p_q + 1'b1;
        end
      end
      StSearch: begin
        if ((query_cnt != '0) && cand) begin
          hit_d   = 1'b1;
          idx_d   = diff[POS_W-1:0];
          seq_d   = win;
          state_d = StDone;
        end else if ((query_cnt == '0) || last_entry) begin
          e_d = '0;
          if (q_q == LastQ) begin
            state_d = StDone;
          end else begin
            q_d = q_q + 1'b1;
          end
        end else begin
          e_d = e_q + 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      ref_q   <= '0;
      read_q  <= '0;
      p_q     <= '0;
      q_q     <= '0;
      e_q     <= '0;
      cnt_q   <= '{default: '0};
      hit_q   <= 1'b0;
      idx_q   <= '0;
      seq_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      read_q  <= read_d;
      p_q     <= p_d;
      q_q     <= q_d;
      e_q     <= e_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      idx_q   <= idx_d;
      seq_q   <= seq_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      seed_mem[build_bkt][build_cnt[EntW-1:0]] <= build_seed;
      pos_mem[build_bkt][build_cnt[EntW-1:0]]  <= p_q;
    end
  end

  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign hit        = hit_q;
  assign index      = idx_q;
  assign seq_window = seq_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_seed_index_aligner.sv
// Randomised bench for seed_index_aligner against a list-based model of the bucket search.
module tb_seed_index_aligner;

  localparam int RB = 50;
  localparam int RDB = 8;
  localparam int SB = 4;
  localparam int WB = 10;
  localparam int DP = 16;
  localparam int PW = $clog2(RB);

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [2*RB-1:0]   reference = '0;
  logic [2*RDB-1:0]  shortread = '0;
  logic              busy, done, hit, overflow;
  logic [PW-1:0]     index;
  logic [2*WB-1:0]   seq_window;

  seed_index_aligner #(
    .REF_BASES(RB), .READ_BASES(RDB), .SEED_BASES(SB), .WINDOW_BASES(WB), .DEPTH(DP), .POS_W(PW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .reference(reference), .shortread(shortread),
    .busy(busy), .done(done), .hit(hit), .index(index), .seq_window(seq_window),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;

  // Expected outputs for the coming negedge, owned by the driver.
  logic            e_busy = 0, e_done = 0, e_hit = 0, e_ovf = 0, e_ovf_chk = 1;
  logic [PW-1:0]   e_idx = '0;
  logic [2*WB-1:0] e_seq = '0;

  // Model results of the current job.
  logic            m_hit, m_ovf;
  int              m_idx, m_len;
  logic [2*WB-1:0] m_seq;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      check("busy", 64'(busy), 64'(e_busy));
      check("done", 64'(done), 64'(e_done));
      check("hit", 64'(hit), 64'(e_hit));
      check("index", 64'(index), 64'(e_idx));
      check("sequence", 64'(seq_window), 64'(e_seq));
      if (e_ovf_chk) check("overflow", 64'(overflow), 64'(e_ovf));
    end
  end

  function automatic int base_of(input logic [2*RB-1:0] v, input int i);
    logic [2*RB-1:0] t;
    t = v >> (2 * i);
    return int'(t[1:0]);
  endfunction

  function automatic logic [2*RB-1:0] put(input logic [2*RB-1:0] v, input int i, input int b);
    logic [2*RB-1:0] t;
    t = v;
    t[2*i +: 2] = 2'(b);
    return t;
  endfunction

  function automatic bit seq_eq(input logic [2*RB-1:0] a, input int ia,
                                input logic [2*RB-1:0] b, input int ib, input int n);
    for (int j = 0; j < n; j++) if (base_of(a, ia + j) != base_of(b, ib + j)) return 0;
    return 1;
  endfunction

  function automatic logic [2*RB-1:0] ext(input logic [2*RDB-1:0] rd);
    logic [2*RB-1:0] t;
    t = '0;
    t[2*RDB-1:0] = rd;
    return t;
  endfunction

  task automatic run_model(input logic [2*RB-1:0] r, input logic [2*RDB-1:0] rd);
    int cnt[4];
    int pos[4][DP];
    logic [2*RB-1:0] rx;
    int cyc, b, n, ps;
    bit ok;
    rx = ext(rd);
    for (int k = 0; k < 4; k++) cnt[k] = 0;
    m_ovf = 0; m_hit = 0; m_idx = 0; m_seq = '0;
    for (int p = 0; p <= RB - SB; p++) begin
      b = base_of(r, p);
      if (cnt[b] < DP) begin
        pos[b][cnt[b]] = p;
        cnt[b]++;
      end else m_ovf = 1;
    end
    cyc = RB - SB + 1;
    for (int q = 0; q <= RDB - SB && !m_hit; q++) begin
      b = base_of(rx, q);
      n = 0;
      for (int k = 0; k < cnt[b] && !m_hit; k++) begin
        ps = pos[b][k];
        n++;
        if (seq_eq(r, ps, rx, q, SB) && ps >= q && ps - q <= RB - WB) begin
          ok = 1;
`ifdef SEED_VERIFY_EN
          ok = (ps - q + RDB <= RB) && seq_eq(r, ps - q, rx, 0, RDB);
`endif
          if (ok) begin
            m_hit = 1;
            m_idx = ps - q;
          end
        end
      end
      cyc += (n == 0) ? 1 : n;
    end
    if (m_hit) for (int j = 0; j < WB; j++) m_seq[2*j +: 2] = 2'(base_of(r, m_idx + j));
    m_len = cyc + 1;
  endtask

  // Called at posedge+1; abort_at >= 0 resets the DUT in that job cycle.
  task automatic run_job(input logic [2*RB-1:0] r, input logic [2*RDB-1:0] rd,
                         input int pulse_at, input int abort_at);
    bit last;
    run_model(r, rd);
    reference = r;
    shortread = rd;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < m_len; c++) begin
      if (c == abort_at) begin
        reset = 1'b0;
        start = 1'b0;
        e_busy = 0; e_done = 0; e_hit = 0; e_idx = '0; e_seq = '0; e_ovf = 0; e_ovf_chk = 1;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
        repeat (150) begin @(posedge clk); #1; end
        return;
      end
      last = (c == m_len - 1);
      e_busy = 1;
      e_done = last;
      e_hit = last ? m_hit : 1'b0;
      e_idx = last ? PW'(m_idx) : '0;
      e_seq = last ? m_seq : '0;
      e_ovf = m_ovf;
      e_ovf_chk = last;
      start = (c == pulse_at);
      @(posedge clk); #1;
    end
    start = 1'b0;
    e_busy = 0; e_done = 0; e_ovf_chk = 1;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  function automatic logic [2*RB-1:0] rand_ref(input int maxb);
    logic [2*RB-1:0] r;
    r = '0;
    for (int i = 0; i < RB; i++) r = put(r, i, $urandom_range(0, maxb));
    return r;
  endfunction

  function automatic bit buckets_fit(input logic [2*RB-1:0] r);
    int cnt[4];
    for (int k = 0; k < 4; k++) cnt[k] = 0;
    for (int p = 0; p <= RB - SB; p++) cnt[base_of(r, p)]++;
    for (int k = 0; k < 4; k++) if (cnt[k] > DP) return 0;
    return 1;
  endfunction

  function automatic logic [2*RB-1:0] gen_unique();
    logic [2*RB-1:0] r;
    bit ok;
    do begin
      r = rand_ref(3);
      ok = buckets_fit(r);
      for (int a = 0; a <= RB - SB && ok; a++)
        for (int b = a + 1; b <= RB - SB && ok; b++)
          if (seq_eq(r, a, r, b, SB)) ok = 0;
    end while (!ok);
    return r;
  endfunction

  function automatic logic [2*RDB-1:0] get_read(input logic [2*RB-1:0] r, input int s);
    logic [2*RDB-1:0] rd;
    for (int j = 0; j < RDB; j++) rd[2*j +: 2] = 2'(base_of(r, s + j));
    return rd;
  endfunction

  function automatic bit seed_in_ref(input logic [2*RB-1:0] r, input logic [2*RDB-1:0] rd,
                                     input int q);
    for (int p = 0; p <= RB - SB; p++) if (seq_eq(r, p, ext(rd), q, SB)) return 1;
    return 0;
  endfunction

  logic [2*RB-1:0]  ref_v;
  logic [2*RDB-1:0] rd_v;
  bit               ok;
  int               s;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;

    // Exact hit at base 20.
    ref_v = gen_unique();
    rd_v = get_read(ref_v, 20);
    run_job(ref_v, rd_v, -1, -1);
    check("exact_hit", 64'(m_hit), 64'd1);
    check("exact_index", 64'(m_idx), 64'd20);
    check("exact_seq", 64'(m_seq), 64'(ref_v[59:40]));
    check("exact_ovf", 64'(m_ovf), 64'd0);

    // Reset mid-job, then an idle stretch with no done.
    run_job(ref_v, rd_v, -1, 20);

    // No seed of the read exists in the reference.
    ref_v = gen_unique();
    do begin
      rd_v = 16'($urandom);
      ok = 1;
      for (int q = 0; q <= RDB - SB; q++) if (seed_in_ref(ref_v, rd_v, q)) ok = 0;
    end while (!ok);
    run_job(ref_v, rd_v, -1, -1);
    check("nomatch_hit", 64'(m_hit), 64'd0);
    check("nomatch_index", 64'(m_idx), 64'd0);

    // Read at base 45 is past the window limit; at base 40 it is the last legal index.
    ref_v = gen_unique();
    do begin
      rd_v = 16'($urandom);
      for (int j = 0; j < 5; j++) rd_v[2*j +: 2] = 2'(base_of(ref_v, 45 + j));
      ok = 1;
      for (int q = 2; q <= RDB - SB; q++) if (seed_in_ref(ref_v, rd_v, q)) ok = 0;
    end while (!ok);
    run_job(ref_v, rd_v, -1, -1);
    check("bound45_hit", 64'(m_hit), 64'd0);
    rd_v = get_read(ref_v, 40);
    run_job(ref_v, rd_v, -1, -1);
    check("bound40_hit", 64'(m_hit), 64'd1);
    check("bound40_index", 64'(m_idx), 64'd40);

    // All-A reference fills bucket A; a start pulsed mid-job must be ignored.
    run_job('0, '0, 10, -1);
    check("ovf_flag", 64'(m_ovf), 64'd1);
    check("ovf_hit", 64'(m_hit), 64'd1);
    check("ovf_index", 64'(m_idx), 64'd0);
    check("ovf_seq", 64'(m_seq), 64'd0);
    check("ovf_len", 64'(m_len), 64'd49);

    // Decoy first seed at base 5, full read at base 30.
    do begin
      ref_v = rand_ref(3);
      rd_v = 16'($urandom);
      for (int j = 0; j < RDB; j++) ref_v = put(ref_v, 30 + j, int'(rd_v[2*j +: 2]));
      for (int j = 0; j < SB; j++) ref_v = put(ref_v, 5 + j, int'(rd_v[2*j +: 2]));
      ref_v = put(ref_v, 9, (int'(rd_v[9:8]) + 1) % 4);
      ok = buckets_fit(ref_v);
      for (int p = 0; p <= RB - SB; p++)
        if (p != 5 && p != 30 && seq_eq(ref_v, p, ext(rd_v), 0, SB)) ok = 0;
    end while (!ok);
    run_job(ref_v, rd_v, -1, -1);
`ifdef SEED_VERIFY_EN
    check("decoy_index", 64'(m_idx), 64'd30);
`else
    check("decoy_index", 64'(m_idx), 64'd5);
`endif

    // Random jobs: free reads, reads taken from the reference, and two-letter references.
    for (int i = 0; i < 24; i++) begin
      case (i % 3)
        0: begin ref_v = rand_ref(3); rd_v = 16'($urandom); end
        1: begin
          ref_v = rand_ref(3);
          s = $urandom_range(0, RB - RDB);
          rd_v = get_read(ref_v, s);
          if ($urandom_range(0, 1) == 1) begin
            s = $urandom_range(0, RDB - 1);
            rd_v[2*s +: 2] = rd_v[2*s +: 2] + 2'd1;
          end
        end
        default: begin
          ref_v = rand_ref(1);
          rd_v = get_read(ref_v, $urandom_range(0, RB - RDB));
        end
      endcase
      run_job(ref_v, rd_v, (i % 4 == 0) ? 30 : -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
